// File: rtl/divide_recombine_if.sv
// Handshake and operand/result bundle for divide_recombine.
// The master drives the request and operands; the slave (the recombiner) returns status and result.
interface divide_recombine_if #(
  parameter int QW = 12,
  parameter int DW = 10,
  parameter int RW = 12
);
  localparam int OW = QW + DW + 1;

  logic          start;
  logic [QW-1:0] quotient;
  logic [DW-1:0] divisor;
  logic [RW-1:0] remainder;
  logic          ready;
  logic          done;
  logic [OW-1:0] dividend;
  logic          rem_err;

  modport master (
    output start, quotient, divisor, remainder,
    input  ready, done, dividend, rem_err
  );

  modport slave (
    input  start, quotient, divisor, remainder,
    output ready, done, dividend, rem_err
  );
endinterface

// File: rtl/divide_recombine.sv
// Rebuilds dividend = quotient*divisor + remainder using a shift-add multiplier and a final add.
// Define DIVIDE_RECOMBINE_EARLY_EXIT_EN to leave MUL as soon as the remaining quotient bits are zero.
module divide_recombine #(
  parameter int QW = 12,
  parameter int DW = 10,
  parameter int RW = 12
) (
  input logic               clk,
  input logic               rst,
  divide_recombine_if.slave bus
);
  localparam int OW = QW + DW + 1;
  localparam int CW = $clog2(QW + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [QW-1:0] mplier_q, mplier_d;
  logic [OW-1:0] mcand_q, mcand_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [DW-1:0] div_q, div_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] dividend_q, dividend_d;
  logic          rem_err_q, rem_err_d;
  logic          readyInt;
  logic          accept;
  logic          lastBit;

  assign readyInt = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept   = readyInt && bus.start;

  // The multiplier register shifts right each MUL cycle, so its remaining bits are the unprocessed ones.
`ifdef DIVIDE_RECOMBINE_EARLY_EXIT_EN
  assign lastBit = (cnt_q == CW'(QW - 1)) || ((mplier_q >> 1) == '0);
`else
  assign lastBit = (cnt_q == CW'(QW - 1));
`endif

  always_comb begin
    state_d    = state_q;
    mplier_d   = mplier_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    div_d      = div_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    rem_err_d  = rem_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          mplier_d = bus.quotient;
          mcand_d  = OW'(bus.divisor);
          div_d    = bus.divisor;
          rem_d    = bus.remainder;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if (lastBit) begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d      = acc_q + OW'(rem_q);
        dividend_d = acc_d;
        rem_err_d  = (div_q == '0) || (OW'(rem_q) >= OW'(div_q));
        state_d    = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mplier_q   <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      dividend_q <= '0;
      rem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mplier_q   <= mplier_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      rem_err_q  <= rem_err_d;
    end
  end

  assign bus.ready    = readyInt;
  assign bus.done     = (state_q == S_DONE);
  assign bus.dividend = dividend_q;
  assign bus.rem_err  = rem_err_q;
endmodule

// File: tb/tb_divide_recombine.sv
// Self-checking bench for divide_recombine: a latency/arithmetic model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_divide_recombine;
  localparam int QW = 12;
  localparam int DW = 10;
  localparam int RW = 12;

`ifdef DIVIDE_RECOMBINE_EARLY_EXIT_EN
  localparam int LAT_Q5  = 5;
  localparam int LAT_Q9  = 6;
  localparam int LAT_Q2  = 4;
  localparam int LAT_Q6  = 5;
  localparam int LAT_Q10 = 6;
  localparam int LAT_Q3  = 4;
  localparam int LAT_Q1  = 3;
  localparam int LAT_Q0  = 3;
`else
  localparam int LAT_Q5  = 14;
  localparam int LAT_Q9  = 14;
  localparam int LAT_Q2  = 14;
  localparam int LAT_Q6  = 14;
  localparam int LAT_Q10 = 14;
  localparam int LAT_Q3  = 14;
  localparam int LAT_Q1  = 14;
  localparam int LAT_Q0  = 14;
`endif
  localparam int LAT_MAX = 14;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  divide_recombine_if #(.QW(QW), .DW(DW), .RW(RW)) bus ();

  divide_recombine #(.QW(QW), .DW(DW), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: an accepted request finishes a fixed number of cycles later with q*b+r.
  function automatic int expLatency(input logic [QW-1:0] q);
`ifdef DIVIDE_RECOMBINE_EARLY_EXIT_EN
    int hi = 0;
    for (int i = 0; i < QW; i++) begin
      if (q[i]) hi = i + 1;
    end
    return ((hi == 0) ? 1 : hi) + 2;
`else
    return QW + 2;
`endif
  endfunction

  bit modelValid = 1'b0;
  int left       = 0;
  int pendDiv    = 0;
  bit pendErr    = 1'b0;
  int expDiv     = 0;
  bit expErr     = 1'b0;
  bit expDone    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      modelValid = 1'b1;
      left       = 0;
      expDone    = 1'b0;
      expDiv     = 0;
      expErr     = 1'b0;
    end else if (left == 0 && bus.start) begin
      left    = expLatency(bus.quotient) - 1;
      pendDiv = int'(bus.quotient) * int'(bus.divisor) + int'(bus.remainder);
      pendErr = (bus.divisor == '0) || (int'(bus.remainder) >= int'(bus.divisor));
      expDone = 1'b0;
    end else begin
      expDone = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          expDone = 1'b1;
          expDiv  = pendDiv;
          expErr  = pendErr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkVal("cycle ready",    32'(bus.ready),    32'(left == 0));
      checkVal("cycle done",     32'(bus.done),     32'(expDone));
      checkVal("cycle dividend", 32'(bus.dividend), 32'(expDiv));
      checkVal("cycle rem_err",  32'(bus.rem_err),  32'(expErr));
    end
  end

  task automatic applyStimulus(input logic [QW-1:0] q, input logic [DW-1:0] b,
                               input logic [RW-1:0] r, input bit now);
    if (!now) @(negedge clk);
    bus.quotient  = q;
    bus.divisor   = b;
    bus.remainder = r;
    bus.start     = 1'b1;
  endtask

  // Waits for done while scrambling operands; optionally re-pulses start at pokeCycle.
  task automatic checkOutput(input string name, input logic [31:0] expDivL, input bit expErrL,
                             input int expLat, input int pokeCycle);
    int cycles = 0;
    bit seen   = 1'b0;
    while (cycles < 40 && !seen) begin
      @(negedge clk);
      cycles++;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (cycles == 1 || cycles == pokeCycle + 1) bus.start = 1'b0;
        if (cycles == pokeCycle) bus.start = 1'b1;
        bus.quotient  = 12'($urandom);
        bus.divisor   = 10'($urandom);
        bus.remainder = 12'($urandom);
      end
    end
    bus.start = 1'b0;
    checkVal({name, " done seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkVal({name, " latency"},  32'(cycles),       32'(expLat));
      checkVal({name, " dividend"}, 32'(bus.dividend), expDivL);
      checkVal({name, " rem_err"},  32'(bus.rem_err),  32'(expErrL));
      checkVal({name, " model"},    32'(expDiv),       expDivL);
    end
  endtask

  initial begin
    int doneCount;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.quotient  = '0;
    bus.divisor   = '0;
    bus.remainder = '0;
    repeat (3) @(negedge clk);
    checkVal("reset ready",    32'(bus.ready),    32'd1);
    checkVal("reset done",     32'(bus.done),     32'd0);
    checkVal("reset dividend", 32'(bus.dividend), 32'd0);
    checkVal("reset rem_err",  32'(bus.rem_err),  32'd0);
    rst = 1'b0;

    applyStimulus(12'd5, 10'd7, 12'd3, 1'b0);
    checkOutput("nominal", 32'd38, 1'b0, LAT_Q5, 0);
    repeat (2) @(negedge clk);

    applyStimulus(12'd4095, 10'd1023, 12'd1022, 1'b0);
    checkOutput("max+poke", 32'd4190207, 1'b0, LAT_MAX, 5);
    repeat (2) @(negedge clk);

    applyStimulus(12'd9, 10'd0, 12'd4, 1'b0);
    checkOutput("div zero", 32'd4, 1'b1, LAT_Q9, 0);
    repeat (2) @(negedge clk);

    applyStimulus(12'd2, 10'd7, 12'd7, 1'b0);
    checkOutput("rem ge div", 32'd21, 1'b1, LAT_Q2, 0);
    repeat (2) @(negedge clk);

    applyStimulus(12'd6, 10'd5, 12'd2, 1'b0);
    checkOutput("b2b first", 32'd32, 1'b0, LAT_Q6, 0);
    applyStimulus(12'd10, 10'd9, 12'd8, 1'b1);
    checkOutput("b2b second", 32'd98, 1'b0, LAT_Q10, 0);
    repeat (2) @(negedge clk);

    applyStimulus(12'd4095, 10'd1023, 12'd1022, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkVal("abort ready",    32'(bus.ready),    32'd1);
    checkVal("abort done",     32'(bus.done),     32'd0);
    checkVal("abort dividend", 32'(bus.dividend), 32'd0);
    checkVal("abort rem_err",  32'(bus.rem_err),  32'd0);
    doneCount = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) doneCount++;
    end
    checkVal("abort no done", 32'(doneCount), 32'd0);

    applyStimulus(12'd3, 10'd4, 12'd1, 1'b0);
    checkOutput("after abort", 32'd13, 1'b0, LAT_Q3, 0);
    repeat (2) @(negedge clk);

    applyStimulus(12'd1, 10'd10, 12'd0, 1'b0);
    checkOutput("q one", 32'd10, 1'b0, LAT_Q1, 0);
    repeat (2) @(negedge clk);

    applyStimulus(12'd0, 10'd5, 12'd2, 1'b0);
    checkOutput("q zero", 32'd2, 1'b0, LAT_Q0, 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
